// File: rtl/prog_freq_div_if.sv
// Control/status bundle for prog_freq_div: run enable, ratio load request and divided outputs.
interface prog_freq_div_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_val;
    logic             load_ack;
    logic             load_err;
    logic             clk_out;
    logic             tick;

    modport master (
        output en, load, div_val,
        input  load_ack, load_err, clk_out, tick
    );

    modport slave (
        input  en, load, div_val,
        output load_ack, load_err, clk_out, tick
    );
endinterface

// File: rtl/prog_freq_div.sv
// Programmable integer clock-enable divider with boundary-synchronised ratio reload.
// Optional PROG_FREQ_DIV_ODD_DUTY50_EN adds a falling-edge stage for 50% duty on odd ratios.
module prog_freq_div #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    prog_freq_div_if.slave bus_io
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ratio_q, ratio_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             phase_q, phase_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             wrap;
    logic             apply;
    logic [WIDTH:0]   high_len;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ratio_d    = ratio_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        phase_d    = 1'b0;
        apply      = 1'b0;
        high_len   = '0;
        wrap       = (cnt_q == ratio_q - WIDTH'(1));

        unique case (state_q)
            StIdle:  apply = pend_q;
            StRun:   apply = pend_q & bus_io.en & wrap;
            default: apply = 1'b0;
        endcase

        if (apply) begin
            ratio_d = pend_val_q;
            pend_d  = 1'b0;
            ack_d   = 1'b1;
        end

        if (!bus_io.en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (state_q == StIdle) begin
            state_d = StRun;
            cnt_d   = '0;
        end else begin
            cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
        end

        // A load on the wrap edge lands after the apply above, so it waits for the next wrap.
        if (bus_io.load) begin
            if (bus_io.div_val >= WIDTH'(2)) begin
                pend_val_d = bus_io.div_val;
                pend_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

`ifdef PROG_FREQ_DIV_ODD_DUTY50_EN
        high_len = {1'b0, ratio_d >> 1};
`else
        high_len = ({1'b0, ratio_d} + 1'b1) >> 1;
`endif
        tick_d  = bus_io.en && (cnt_d == '0);
        phase_d = bus_io.en && ({1'b0, cnt_d} < high_len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ratio_q    <= WIDTH'(DEFAULT_DIV);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            phase_q    <= 1'b0;
            tick_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ratio_q    <= ratio_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            phase_q    <= phase_d;
            tick_q     <= tick_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

`ifdef PROG_FREQ_DIV_ODD_DUTY50_EN
    logic neg_q;

    // Half-cycle extension of the high phase, only for odd ratios.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= phase_q & ratio_q[0];
        end
    end

    assign bus_io.clk_out = phase_q | (neg_q & (state_q == StRun));
`else
    assign bus_io.clk_out = phase_q;
`endif

    assign bus_io.tick     = tick_q;
    assign bus_io.load_ack = ack_q;
    assign bus_io.load_err = err_q;

endmodule

// File: tb/tb_prog_freq_div.sv
// Self-checking bench for prog_freq_div: fixed vector table, corner sequences, random run vs model.
module tb_prog_freq_div;

    logic clk;
    logic rst;

    prog_freq_div_if #(.WIDTH(8)) bus ();

    prog_freq_div #(
        .WIDTH      (8),
        .DEFAULT_DIV(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: position within the current period, ratio in force, pending ratio.
    int  m_n;
    int  m_pos;
    bit  m_run;
    int  pend[$];
    bit  m_ack;
    bit  m_err;

    function automatic void model_reset();
        m_n   = 4;
        m_pos = 0;
        m_run = 1'b0;
        m_ack = 1'b0;
        m_err = 1'b0;
        pend.delete();
    endfunction

    function automatic void model_step(bit en, bit ld, int dv);
        bit wrap_now;
        bit apply;
        int nxt;
        wrap_now = m_run && en && (m_pos == m_n - 1);
        apply    = (pend.size() != 0) && (!m_run || wrap_now);
        nxt      = wrap_now ? 0 : m_pos + 1;
        m_ack    = apply;
        if (apply) begin
            m_n = pend[0];
            pend.delete();
        end
        if (!en) begin
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_pos = 0;
        end else begin
            m_pos = nxt;
        end
        m_err = 1'b0;
        if (ld) begin
            if (dv >= 2) begin
                pend.delete();
                pend.push_back(dv);
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    task automatic check_vals(input string name, input bit ack, input bit err, input bit co,
                              input bit tk);
        logic [3:0] act;
        logic [3:0] exp;
        act = {bus.load_ack, bus.load_err, bus.clk_out, bus.tick};
        exp = {ack, err, co, tk};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t {ack,err,clk_out,tick} got %b expected %b", name, $time,
                     act, exp);
        end
    endtask

    task automatic check_model(input string name);
        check_vals(name, m_ack, m_err, m_run && (m_pos < (m_n + 1) / 2), m_run && (m_pos == 0));
    endtask

    task automatic step(input bit en, input bit ld, input int dv);
        bus.en      = en;
        bus.load    = ld;
        bus.div_val = 8'(dv);
        @(posedge clk);
        model_step(en, ld, dv);
        #1;
        bus.load = 1'b0;
    endtask

    typedef struct {
        bit       en;
        bit       ld;
        int       dv;
        bit       ack;
        bit       err;
        bit       co;
        bit       tk;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int acks;
        int guard;
        bit en_r;
        bit ld_r;
        int dv_r;

        // en, ld, dv -> ack, err, clk_out, tick (observed after the edge)
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 1});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 1});
        tbl.push_back('{1, 1, 1, 0, 1, 1, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 1});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 1, 7, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 1, 0, 1, 1});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 1, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0});

        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.load    = 1'b0;
        bus.div_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_vals("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].ld, tbl[i].dv);
            check_vals($sformatf("table[%0d]", i), tbl[i].ack, tbl[i].err, tbl[i].co, tbl[i].tk);
        end

        // N=5 loaded while idle, then run two periods.
        step(0, 1, 5);
        check_model("idle_load5");
        step(0, 0, 0);
        check_model("idle_ack5");
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0);
            check_model("run5");
        end

        // Two loads within one period: last wins, single ack.
        acks = 0;
        step(1, 1, 6);
        check_model("double_load_a");
        acks += int'(bus.load_ack);
        step(1, 1, 3);
        check_model("double_load_b");
        acks += int'(bus.load_ack);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            check_model("run3");
            acks += int'(bus.load_ack);
        end
        n_vec++;
        if (acks != 1) begin
            n_bad++;
            $display("FAIL single_ack count got %0d expected 1", acks);
        end

        // Load presented on the wrap edge applies only at the following wrap.
        guard = 0;
        while (m_pos != m_n - 1 && guard < 10) begin
            step(1, 0, 0);
            check_model("to_wrap");
            guard++;
        end
        step(1, 1, 6);
        check_model("load_on_wrap");
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0);
            check_model("after_wrap_load");
        end

        // en drops with a load pending: period abandoned, ratio applied in idle.
        step(1, 1, 4);
        check_model("pend_before_stop");
        step(0, 0, 0);
        check_model("stop");
        step(0, 0, 0);
        check_model("idle_apply");

        // Asynchronous reset mid-period at N=7, cnt=2.
        step(0, 1, 7);
        check_model("load7");
        step(0, 0, 0);
        check_model("apply7");
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0);
            check_model("run7");
        end
        #2;
        rst = 1'b1;
        #1;
        check_vals("async_reset", 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1, 0, 0);
            check_model("resume4");
        end

        for (int i = 0; i < 3000; i++) begin
            en_r = ($urandom_range(0, 15) != 0);
            ld_r = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) dv_r = int'($urandom_range(0, 1));
            else if ($urandom_range(0, 1) == 1) dv_r = int'($urandom_range(2, 9));
            else dv_r = int'($urandom_range(2, 255));
            step(en_r, ld_r, dv_r);
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
